// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_IDLE  = 2'd0,
    HZ_PEND  = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_e;

  localparam logic HZ_EN  = 1'b1;
  localparam logic HZ_DIS = 1'b0;

  // Width of a per-stage bus (one bit per pipeline stage).
  function automatic int unsigned stall_bus_w(input int unsigned stages);
    return stages;
  endfunction

  // Width needed to name a stage index.
  function automatic int unsigned src_w(input int unsigned stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

endpackage

// File: rtl/msb_fill.sv
// Highest-set-bit to thermometer fill: out[i] = OR of in[Width-1:i].
module msb_fill #(
  parameter int unsigned Width = 5
) (
  input  logic [Width-1:0] req_i,
  output logic [Width-1:0] fill_o
);

  logic acc;

  always_comb begin
    acc    = 1'b0;
    fill_o = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      acc       = acc | req_i[i];
      fill_o[i] = acc;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// N-stage hazard controller: freeze mask, bubbles, flush sequencing, stall watchdog.
// Optional perf counters are built when STALL_PERF_EN is defined.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned STAGES     = 5,
  parameter int unsigned FLUSH_HOLD = 1,
  parameter int unsigned WDOG_LIMIT = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             rdy_i,
  input  logic [stall_bus_w(STAGES)-1:0]   stall_req_i,
  input  logic                             flush_req_i,
  input  logic [src_w(STAGES)-1:0]         flush_src_i,
  output logic [stall_bus_w(STAGES)-1:0]   stall_o,
  output logic [stall_bus_w(STAGES)-1:0]   bubble_o,
  output logic [stall_bus_w(STAGES)-1:0]   flush_o,
  output logic                             flush_busy_o,
  output logic                             stall_timeout_o,
  output logic [CNT_W-1:0]                 perf_stall_cycles_o,
  output logic [CNT_W-1:0]                 perf_flush_cnt_o
);

  localparam int unsigned SrcW  = src_w(STAGES);
  localparam int unsigned HoldW = $clog2(FLUSH_HOLD + 1);

`ifdef STALL_PERF_EN
  localparam logic PerfEn = HZ_EN;
`else
  localparam logic PerfEn = HZ_DIS;
`endif

  hz_state_e        state_q, state_d;
  logic [SrcW-1:0]  pend_src_q, pend_src_d;
  logic [SrcW-1:0]  act_src_q, act_src_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             timeout_q, timeout_d;

  logic [STAGES-1:0] req_eff, fill;
  logic [SrcW-1:0]   cur_src;
  logic              accept, issue, any_stall;

  // Flush is purely a function of registered state, so the freeze mask has no loop through it.
  always_comb begin
    flush_o = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      flush_o[k] = (state_q == HZ_FLUSH) && (k < 32'(act_src_q));
    end
  end

  assign req_eff = stall_req_i & ~flush_o;

  msb_fill #(
    .Width(STAGES)
  ) u_msb_fill (
    .req_i (req_eff),
    .fill_o(fill)
  );

  always_comb begin
    if (rst_i) begin
      stall_o = '0;
    end else if (!rdy_i) begin
      stall_o = '1;
    end else begin
      stall_o = fill;
    end
  end

  assign bubble_o     = {stall_o[STAGES-2:0] & ~stall_o[STAGES-1:1], 1'b0};
  assign any_stall    = |stall_o;
  assign flush_busy_o = (state_q != HZ_IDLE);

  always_comb begin
    state_d    = state_q;
    pend_src_d = pend_src_q;
    act_src_d  = act_src_q;
    hold_d     = hold_q;
    issue      = 1'b0;
    cur_src    = (state_q == HZ_PEND) ? pend_src_q : act_src_q;
    // A younger source than the current one is already covered by the flush in progress.
    accept     = flush_req_i && ((state_q == HZ_IDLE) || (flush_src_i > cur_src));
    if (rdy_i) begin
      if (accept) begin
        if (!stall_o[flush_src_i]) begin
          state_d   = HZ_FLUSH;
          act_src_d = flush_src_i;
          hold_d    = HoldW'(FLUSH_HOLD);
          issue     = 1'b1;
        end else begin
          state_d    = HZ_PEND;
          pend_src_d = flush_src_i;
        end
      end else if (state_q == HZ_PEND) begin
        if (!stall_o[pend_src_q]) begin
          state_d   = HZ_FLUSH;
          act_src_d = pend_src_q;
          hold_d    = HoldW'(FLUSH_HOLD);
          issue     = 1'b1;
        end
      end else if (state_q == HZ_FLUSH) begin
        hold_d = hold_q - HoldW'(1);
        if (hold_q == HoldW'(1)) begin
          state_d = HZ_IDLE;
        end
      end
    end
  end

  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    if (rdy_i) begin
      if (any_stall) begin
        wdog_d = (&wdog_q) ? wdog_q : wdog_q + CNT_W'(1);
      end else begin
        wdog_d = '0;
      end
      if (wdog_d >= CNT_W'(WDOG_LIMIT)) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= HZ_IDLE;
      pend_src_q <= '0;
      act_src_q  <= '0;
      hold_q     <= '0;
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_src_q <= pend_src_d;
      act_src_q  <= act_src_d;
      hold_q     <= hold_d;
      wdog_q     <= wdog_d;
      timeout_q  <= timeout_d;
    end
  end

  assign stall_timeout_o = timeout_q;

  if (PerfEn) begin : g_perf
    logic [CNT_W-1:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        perf_stall_q <= '0;
        perf_flush_q <= '0;
      end else if (rdy_i) begin
        if (any_stall && !(&perf_stall_q)) begin
          perf_stall_q <= perf_stall_q + CNT_W'(1);
        end
        if (issue && !(&perf_flush_q)) begin
          perf_flush_q <= perf_flush_q + CNT_W'(1);
        end
      end
    end

    assign perf_stall_cycles_o = perf_stall_q;
    assign perf_flush_cnt_o    = perf_flush_q;
  end else begin : g_no_perf
    logic unused_issue;
    assign unused_issue        = issue;
    assign perf_stall_cycles_o = '0;
    assign perf_flush_cnt_o    = '0;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plan scenarios followed by random traffic, all checked against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned S     = 5;
  localparam int          HOLD  = 2;
  localparam int          LIMIT = 4;
  localparam int unsigned CW    = 16;
  localparam int          SAT   = 65535;

`ifdef STALL_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, rdy, flush_req;
  logic [S-1:0]  stall_req;
  logic [2:0]    flush_src;
  logic [S-1:0]  stall, bubble, flush;
  logic          flush_busy, stall_timeout;
  logic [CW-1:0] perf_stall_cycles, perf_flush_cnt;

  pipe_hazard_ctrl #(
    .STAGES    (S),
    .FLUSH_HOLD(HOLD),
    .WDOG_LIMIT(LIMIT),
    .CNT_W     (CW)
  ) u_dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .rdy_i              (rdy),
    .stall_req_i        (stall_req),
    .flush_req_i        (flush_req),
    .flush_src_i        (flush_src),
    .stall_o            (stall),
    .bubble_o           (bubble),
    .flush_o            (flush),
    .flush_busy_o       (flush_busy),
    .stall_timeout_o    (stall_timeout),
    .perf_stall_cycles_o(perf_stall_cycles),
    .perf_flush_cnt_o   (perf_flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: pending source (-1 = none), active source and remaining flush cycles.
  int m_pend, m_act, m_left, m_run, m_perf_stall, m_perf_flush;
  bit m_timeout;
  logic [S-1:0] e_stall, e_bubble, e_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_pend = -1; m_act = 0; m_left = 0; m_run = 0;
    m_perf_stall = 0; m_perf_flush = 0; m_timeout = 1'b0;
  endtask

  function automatic logic [S-1:0] model_stall(input bit r, input bit rd, input logic [S-1:0] req,
                                               input logic [S-1:0] fl);
    logic [S-1:0] eff;
    if (r) return '0;
    if (!rd) return '1;
    eff = req & ~fl;
    for (int i = S - 1; i >= 0; i--) begin
      if (eff[i]) return S'((32'd1 << (i + 1)) - 1);
    end
    return '0;
  endfunction

  task automatic drive(input bit r, input bit rd, input logic [S-1:0] req, input bit fr,
                       input int fs);
    rst = r; rdy = rd; stall_req = req; flush_req = fr; flush_src = 3'(fs);
    @(negedge clk);
    e_flush  = (m_left > 0) ? S'((32'd1 << m_act) - 1) : '0;
    e_stall  = model_stall(r, rd, req, e_flush);
    e_bubble = '0;
    for (int k = 1; k < S; k++) e_bubble[k] = e_stall[k-1] & ~e_stall[k];
    check("stall", 32'(stall), 32'(e_stall));
    check("bubble", 32'(bubble), 32'(e_bubble));
    check("flush", 32'(flush), 32'(e_flush));
    check("flush_busy", 32'(flush_busy), 32'((m_pend >= 0) || (m_left > 0)));
    check("stall_timeout", 32'(stall_timeout), 32'(m_timeout));
    check("perf_stall", 32'(perf_stall_cycles), PerfEn ? 32'(m_perf_stall) : 32'd0);
    check("perf_flush", 32'(perf_flush_cnt), PerfEn ? 32'(m_perf_flush) : 32'd0);
  endtask

  task automatic tick();
    int cur, fs;
    bit issued;
    if (rst) begin
      model_reset();
    end else if (rdy) begin
      cur    = (m_pend >= 0) ? m_pend : ((m_left > 0) ? m_act : -1);
      fs     = int'(flush_src);
      issued = 1'b0;
      if (flush_req && (cur < 0 || fs > cur)) begin
        if (!e_stall[fs]) begin
          m_act = fs; m_left = HOLD; m_pend = -1; issued = 1'b1;
        end else begin
          m_pend = fs; m_left = 0;
        end
      end else if (m_pend >= 0) begin
        if (!e_stall[m_pend]) begin
          m_act = m_pend; m_left = HOLD; m_pend = -1; issued = 1'b1;
        end
      end else if (m_left > 0) begin
        m_left--;
      end
      if (|e_stall) begin
        if (m_run < SAT) m_run++;
        if (m_perf_stall < SAT) m_perf_stall++;
      end else begin
        m_run = 0;
      end
      if (m_run >= LIMIT) m_timeout = 1'b1;
      if (issued && m_perf_flush < SAT) m_perf_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit           r, rd, fr;
    logic [S-1:0] req;
    rst = 1'b1; rdy = 1'b1; stall_req = '0; flush_req = 1'b0; flush_src = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset and freeze mask
    drive(1, 1, 5'b11111, 0, 0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_timeout", 32'(stall_timeout), 32'd0);
    tick();
    drive(0, 1, 5'b11111, 0, 0);
    check("post_rst_stall", 32'(stall), 32'h1f);
    tick();
    drive(0, 1, 5'b01010, 0, 0);
    check("mask_stall", 32'(stall), 32'h0f);
    check("mask_bubble", 32'(bubble), 32'h10);
    tick();
    drive(0, 0, 5'b01010, 0, 0);
    check("rdy0_stall", 32'(stall), 32'h1f);
    check("rdy0_bubble", 32'(bubble), 32'd0);
    tick();

    // Direct flush from stage 3
    drive(1, 1, '0, 0, 0); tick();
    drive(0, 1, '0, 1, 3); tick();
    drive(0, 1, '0, 0, 0);
    check("direct_t1", 32'(flush), 32'h07);
    tick();
    drive(0, 1, '0, 0, 0);
    check("direct_t2", 32'(flush), 32'h07);
    tick();
    drive(0, 1, '0, 0, 0);
    check("direct_t3", 32'(flush), 32'd0);
    check("direct_cnt", 32'(perf_flush_cnt), PerfEn ? 32'd1 : 32'd0);
    tick();

    // Deferred flush behind a stage-4 stall
    drive(1, 1, '0, 0, 0); tick();
    drive(0, 1, 5'b10000, 1, 2); tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 5'b10000, 0, 0);
      check("defer_busy", 32'(flush_busy), 32'd1);
      check("defer_flush", 32'(flush), 32'd0);
      tick();
    end
    drive(0, 1, '0, 0, 0);
    check("defer_release", 32'(flush), 32'd0);
    tick();
    drive(0, 1, '0, 0, 0);
    check("defer_issue", 32'(flush), 32'h03);
    tick();

    // Override while flushing
    drive(1, 1, '0, 0, 0); tick();
    drive(0, 1, '0, 1, 2); tick();
    drive(0, 1, '0, 1, 1);
    check("ovr_drop", 32'(flush), 32'h03);
    tick();
    drive(0, 1, '0, 1, 4); tick();
    drive(0, 1, '0, 0, 0);
    check("ovr_t1", 32'(flush), 32'h0f);
    tick();
    drive(0, 1, '0, 0, 0);
    check("ovr_t2", 32'(flush), 32'h0f);
    tick();
    drive(0, 1, '0, 0, 0);
    check("ovr_done", 32'(flush_busy), 32'd0);
    tick();

    // Watchdog
    drive(1, 1, '0, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 5'b00001, 0, 0);
      check("wdog_pre", 32'(stall_timeout), 32'd0);
      tick();
    end
    drive(0, 1, '0, 0, 0);
    check("wdog_set", 32'(stall_timeout), 32'd1);
    tick();
    drive(0, 1, '0, 0, 0);
    check("wdog_sticky", 32'(stall_timeout), 32'd1);
    tick();
    drive(1, 1, '0, 0, 0); tick();
    drive(0, 1, '0, 0, 0);
    check("wdog_clr", 32'(stall_timeout), 32'd0);
    tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      rd = ($urandom_range(0, 99) < 85);
      for (int b = 0; b < S; b++) req[b] = ($urandom_range(0, 9) == 0);
      fr = rd && ($urandom_range(0, 4) == 0);
      drive(r, rd, req, fr, int'($urandom_range(0, S - 1)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard controller that generalises the fixed five-stage stall encoder to an N-stage pipeline with flush sequencing. It merges per-stage stall requests into a thermometer freeze mask with bubble markers, and latches single-cycle flush requests. It defers flushes while the resolving stage is frozen and holds the flush for a programmable number of cycles. It also runs a stall watchdog and sits between the pipeline stages and every stage register's enable/clear inputs.

## Interface
- STAGES, 5: pipeline stages; index 0 = IF (youngest), STAGES-1 = oldest.
- FLUSH_HOLD, 1: cycles flush stays asserted once issued (≥1).
- WDOG_LIMIT, 1024: consecutive stalled cycles before timeout.
- CNT_W, 16: width of watchdog and performance counters.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global ready; low freezes whole pipeline.
- stall_req  in  STAGES  per-stage stall request.
- flush_req  in  1  single-cycle flush pulse.
- flush_src  in  $clog2(STAGES)  stage resolving the flush; stages below it are killed.
- stall  out  STAGES  per-stage freeze.
- bubble  out  STAGES  stage k receives a bubble this cycle.
- flush  out  STAGES  per-stage clear.
- flush_busy  out  1  flush pending or in progress.
- stall_timeout  out  1  sticky watchdog flag.
- perf_stall_cycles  out  CNT_W  cycles with any stall bit set.
- perf_flush_cnt  out  CNT_W  flushes issued.

## Operation
- Effective request: req_eff = stall_req & ~flush. Requests from stages being flushed are ignored.
- Freeze mask: if i is the highest index with req_eff[i]=1, then stall[0..i]=1 and the rest are 0. With no request, stall=0. With rdy=0, stall is all ones and bubble=0.
- bubble[k] = stall[k-1] & ~stall[k] for k≥1. bubble[0]=0.
- Flush FSM states are IDLE, PEND and FLUSH. The registers are pend_src, act_src and hold_cnt.
- IDLE + flush_req:
  - if stall[flush_src]=0, go to FLUSH with act_src=flush_src and hold_cnt=FLUSH_HOLD.
  - otherwise go to PEND with pend_src=flush_src.
- PEND: on the first cycle with rdy=1 and stall[pend_src]=0, go to FLUSH.
- FLUSH: flush[k]=1 for k<act_src. hold_cnt decrements on cycles with rdy=1. When it reaches 0, return to IDLE. If another request is accepted, reload instead.
- New flush_req during PEND or FLUSH:
  - accepted (replacing src and restarting) only if flush_src > current src;
  - otherwise dropped, because the younger source is already killed.
- flush_busy = (state != IDLE).
- Watchdog: counts consecutive cycles with rdy=1 and any stall bit set; clears on a stall-free cycle. Reaching WDOG_LIMIT sets stall_timeout, which stays set until rst. The count saturates.
- Counters saturate at all ones and never wrap.

## Timing
- stall and bubble are combinational from stall_req, rdy and the registered flush, with zero-cycle latency.
- flush is registered. An accepted flush_req at cycle t drives flush during cycles t+1 .. t+FLUSH_HOLD, assuming rdy stays high.
- A deferred flush issues one cycle after the blocking stall clears.
- rdy=0 freezes the FSM, hold_cnt, the watchdog and the perf counters. flush outputs keep their value.
- In reset (rst=1 at the edge) all registers clear: state IDLE, flush=0, flush_busy=0, stall_timeout=0, counters 0. While rst is high, stall=0 and bubble=0, regardless of rdy.
- Reset mid-flush or mid-PEND abandons the flush; no flush is issued afterwards.
- flush_req coincident with rst is ignored.

## Configuration
- Macro: STALL_PERF_EN.
- Defined: perf_stall_cycles increments on each rdy=1 cycle with any stall bit set. perf_flush_cnt increments on each cycle that enters or reloads FLUSH.
- Undefined: the counters are not instantiated and both ports are tied to 0. The watchdog is unaffected.

## Structure
- Shared package hazard_pkg holds:
  - state encodings (HZ_IDLE, HZ_PEND, HZ_FLUSH);
  - the StallBus width macro generalised to STAGES;
  - enable/disable constants.
- One sub-module, msb_fill: parametrised highest-set-bit to thermometer-fill generator used for the freeze mask.

## Test plan
All scenarios use STAGES=5 and FLUSH_HOLD=2 unless stated otherwise.
- Reset: rst=1 with stall_req=5'b11111 → stall=0, flush=0, stall_timeout=0. After release, stall=5'b11111.
- Freeze mask: stall_req=5'b01010 → stall=5'b01111, bubble=5'b10000. Then rdy=0 → stall=5'b11111, bubble=0.
- Direct flush: flush_req with flush_src=3 at cycle t, no stalls → flush=5'b00111 at t+1 and t+2, 0 at t+3. perf_flush_cnt=1 with STALL_PERF_EN.
- Deferred flush: stall_req[4]=1 for 3 cycles while flush_src=2 → flush_busy=1 and flush=0 during the stall. flush=5'b00011 on the cycle after stall_req[4] drops.
- Override: flush_src=1 during FLUSH → ignored. flush_src=4 → flush=5'b01111, hold restarts for 2 cycles.
- Watchdog with WDOG_LIMIT=4: stall_req[0] held 4 cycles → stall_timeout=1 and stays 1 after the stall clears, until rst.
